// File: rtl/alu_issue_queue.sv
// rtl/alu_issue_queue.sv - instruction FIFO feeding a combinational ALU with a registered result handshake
// Optional feature macro: ALU_ISSUE_ILLEGAL_CHECK_EN (drop opcodes 0 and 9..15, pulse err)
module alu_issue_queue #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_opcode,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    output logic [3:0] alu_opcode,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [3:0] alu_c,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_result,
    output logic [3:0] out_opcode,
    output logic       err,
    output logic [4:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        HOLD
    } state_t;

    state_t          state_q, state_d;
    logic [11:0]     mem_q [DEPTH];
    logic [PW-1:0]   wptr_q, rptr_q;
    logic [4:0]      count_q, count_d;
    logic [3:0]      alu_opcode_q, alu_a_q, alu_b_q;
    logic [3:0]      out_result_q, out_opcode_q;
    logic            out_valid_q, err_q;
    logic            full, empty, push, pop, issue, drop, capture, release_out;
    logic            head_illegal;
    logic [11:0]     head;

    assign full     = (count_q == 5'(DEPTH));
    assign empty    = (count_q == 5'd0);
    assign in_ready = !full && !rst;
    assign push     = in_valid && in_ready;
    assign head     = mem_q[rptr_q];
    assign count_d  = count_q + {4'd0, push} - {4'd0, pop};

`ifdef ALU_ISSUE_ILLEGAL_CHECK_EN
    assign head_illegal = (head[11:8] == 4'd0) || (head[11:8] >= 4'd9);
`else
    assign head_illegal = 1'b0;
`endif

    // Next-state logic: decide pops, issues, drops and result capture/release
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        issue       = 1'b0;
        drop        = 1'b0;
        capture     = 1'b0;
        release_out = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (head_illegal) begin
                        drop = 1'b1;
                    end else begin
                        issue   = 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                capture = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (out_valid_q && out_ready) begin
                    release_out = 1'b1;
                    state_d     = IDLE;
                    if (!empty) begin
                        pop = 1'b1;
                        if (head_illegal) begin
                            drop = 1'b1;
                        end else begin
                            issue   = 1'b1;
                            state_d = ISSUE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= {in_opcode, in_a, in_b};
        end
    end

    // State, pointers, ALU drive and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= 5'd0;
            alu_opcode_q <= 4'd0;
            alu_a_q      <= 4'd0;
            alu_b_q      <= 4'd0;
            out_result_q <= 4'd0;
            out_opcode_q <= 4'd0;
            out_valid_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= drop;
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (issue) begin
                alu_opcode_q <= head[11:8];
                alu_a_q      <= head[7:4];
                alu_b_q      <= head[3:0];
            end
            if (capture) begin
                out_result_q <= alu_c;
                out_opcode_q <= alu_opcode_q;
                out_valid_q  <= 1'b1;
            end else if (release_out) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign alu_opcode = alu_opcode_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_opcode = out_opcode_q;
    assign err        = err_q;
    assign count      = count_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb/tb_alu_issue_queue.sv - scoreboard bench for alu_issue_queue with a behavioural ALU and queue model
module tb_alu_issue_queue;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_opcode, in_a, in_b;
    logic [3:0] alu_opcode, alu_a, alu_b, alu_c;
    logic       out_valid, out_ready;
    logic [3:0] out_result, out_opcode;
    logic       err;
    logic [4:0] count;

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_q[$];
    int         hs_cycles[$];
    int         err_exp = 0;
    int         err_seen = 0;
    int         cyc = 0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_out = 8'd0;

    always #5 clk = ~clk;

    alu_issue_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_opcode(out_opcode),
        .err(err), .count(count)
    );

    function automatic logic [3:0] alu_fn(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd3:    return a & b;
            4'd4:    return a | b;
            4'd5:    return a ^ b;
            4'd6:    return ~a;
            4'd7:    return a << 1;
            4'd8:    return a >> 1;
            default: return a + b + op;
        endcase
    endfunction

    function automatic bit is_dropped(input logic [3:0] op);
`ifdef ALU_ISSUE_ILLEGAL_CHECK_EN
        return (op == 4'd0) || (op >= 4'd9);
`else
        return 1'b0;
`endif
    endfunction

    always_comb alu_c = alu_fn(alu_opcode, alu_a, alu_b);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard feed: every accepted instruction produces one expected result or one err pulse
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) begin
            if (is_dropped(in_opcode)) err_exp++;
            else exp_q.push_back({in_opcode, alu_fn(in_opcode, in_a, in_b)});
        end
    end

    // Monitor: compare each handshaken result and check output stability while stalled
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (err) err_seen++;
            check("count_bound", count <= 5'(DEPTH), 1);
            if (out_valid && prev_hold) check("hold_stable", {out_opcode, out_result}, prev_out);
            if (out_valid && out_ready) begin
                hs_cycles.push_back(cyc);
                check("result_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("result", {out_opcode, out_result}, exp_q.pop_front());
            end
            prev_hold = out_valid && !out_ready;
            prev_out  = {out_opcode, out_result};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        bit ok = 1'b0;
        in_opcode = op; in_a = a; in_b = b; in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            step();
        end
        in_valid = 1'b0;
        if (!ok) check("push_timeout", 0, 1);
    endtask

    task automatic drain();
        int i = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (i < 300 && (exp_q.size() != 0 || out_valid || count != 0)) begin
            step();
            i++;
        end
        check("drain_empty", exp_q.size(), 0);
        check("drain_idle", {out_valid, count}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] snap;
        int n;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_opcode = 4'd0; in_a = 4'd0; in_b = 4'd0;
        step(); step();
        check("reset_in_ready", in_ready, 0);
        check("reset_count", count, 0);
        check("reset_out", {out_valid, out_result, out_opcode, err}, 0);
        check("reset_alu", {alu_opcode, alu_a, alu_b}, 0);
        rst = 1'b0;
        step();
        check("ready_after_reset", in_ready, 1);

        // First-instruction latency
        out_ready = 1'b1;
        in_opcode = 4'd1; in_a = 4'd4; in_b = 4'd3; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("e1_alu_drive", {alu_opcode, alu_a, alu_b}, 12'h143);
        check("e1_out_valid", out_valid, 0);
        step();
        check("e2_out_valid", out_valid, 1);
        check("e2_out_result", out_result, 4'd7);
        drain();

        // Fill to full, refused push, stall then release
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) push(4'(i), 4'(i), 4'(i + 1));
        check("full_count", count, DEPTH);
        check("full_in_ready", in_ready, 0);
        in_opcode = 4'd6; in_a = 4'd1; in_b = 4'd1; in_valid = 1'b1;
        repeat (3) step();
        in_valid = 1'b0;
        check("refused_count", count, DEPTH);
        snap = {out_opcode, out_result};
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_valid", out_valid, 1);
            check("stall_data", {out_opcode, out_result}, snap);
        end
        hs_cycles.delete();
        out_ready = 1'b1;
        n = 0;
        while (hs_cycles.size() < 5 && n < 40) begin step(); n++; end
        check("b2b_results", hs_cycles.size(), 5);
        for (int i = 1; i < hs_cycles.size(); i++) check("b2b_spacing", hs_cycles[i] - hs_cycles[i-1], 2);
        drain();

        // Illegal opcode handling
        n = err_seen;
        hs_cycles.delete();
        push(4'd0, 4'd1, 4'd2);
        push(4'd5, 4'b1110, 4'b1100);
        repeat (10) step();
`ifdef ALU_ISSUE_ILLEGAL_CHECK_EN
        check("illegal_err_pulses", err_seen - n, 1);
        check("illegal_results", hs_cycles.size(), 1);
`else
        check("illegal_err_pulses", err_seen - n, 0);
        check("illegal_results", hs_cycles.size(), 2);
`endif
        drain();

        // Reset in HOLD with queued entries
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push(4'(i), 4'(i + 3), 4'(i));
        check("pre_reset_count", count, 3);
        check("pre_reset_valid", out_valid, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        exp_q.delete();
        #1;
        check("async_reset_out", {out_valid, count}, 0);
        check("async_reset_ready", in_ready, 0);
        @(negedge clk);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        hs_cycles.delete();
        repeat (8) step();
        check("no_stale_result", {hs_cycles.size() != 0, out_valid, count}, 0);

        // Simultaneous push and pop at count 2 across pointer wrap
        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) push(4'(i), 4'(i), 4'(i));
        check("steady_start_count", count, 2);
        for (int i = 0; i < 10; i++) begin
            check("steady_hold", out_valid, 1);
            in_opcode = 4'($urandom_range(1, 8)); in_a = 4'($urandom); in_b = 4'($urandom);
            in_valid = 1'b1; out_ready = 1'b1;
            step();
            in_valid = 1'b0; out_ready = 1'b0;
            check("steady_count", count, 2);
            step();
        end
        drain();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_opcode = 4'($urandom); in_a = 4'($urandom); in_b = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();
        repeat (3) step();
        check("err_pulse_total", err_seen, err_exp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
